// File: rtl/conv_pkg.sv
// Shared geometry for the binary conv front end: frame/window defaults,
// derived output dimensions and counter-width helper.
package conv_pkg;

  localparam int unsigned K          = 4;
  localparam int unsigned IMG_W      = 12;
  localparam int unsigned IMG_H      = 12;
  localparam int unsigned DATA_WIDTH = 1;

  localparam int unsigned OUT_W         = IMG_W - K + 1;
  localparam int unsigned OUT_H         = IMG_H - K + 1;
  localparam int unsigned WIN_PER_FRAME = OUT_W * OUT_H;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam int unsigned ROW_W = cnt_w(IMG_H);

endpackage

// File: rtl/conv_line_buf.sv
// (K-1)-row line buffer: per-column shift of rows on write, combinational
// read of the K-1 stored pixels at the addressed column, oldest first.
module conv_line_buf #(
  parameter int unsigned K          = conv_pkg::K,
  parameter int unsigned IMG_W      = conv_pkg::IMG_W,
  parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int unsigned AW         = conv_pkg::cnt_w(IMG_W)
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [AW-1:0]                   addr,
  input  logic [DATA_WIDTH-1:0]           wdata,
  output logic [(K-1)*DATA_WIDTH-1:0]     rdata
);
  import conv_pkg::*;

  // Contents are don't-care after reset, so the storage carries no reset.
  logic [DATA_WIDTH-1:0] mem [K-1][IMG_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(K) - 2; i++) begin
        mem[i][addr] <= mem[i+1][addr];
      end
      mem[K-2][addr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(K) - 1; i++) begin
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][addr];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming stride-1 KxK window generator feeding the binary conv engine.
// Optional start-of-frame input enabled by defining CONV_WIN_SOF_EN.
module conv_window_gen #(
  parameter int unsigned K          = conv_pkg::K,
  parameter int unsigned IMG_W      = conv_pkg::IMG_W,
  parameter int unsigned IMG_H      = conv_pkg::IMG_H,
  parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [DATA_WIDTH-1:0]         pix_data,
`ifdef CONV_WIN_SOF_EN
  input  logic                          pix_sof,
`endif
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [K*K*DATA_WIDTH-1:0]     win_data,
  output logic                          win_last
);
  import conv_pkg::*;

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam int unsigned DW = DATA_WIDTH;

  logic [CW-1:0]         col_q, col_d, col_cur;
  logic [RW-1:0]         row_q, row_d, row_cur;
  logic [(K-1)*DW-1:0]   lb_rd;
  logic [K*K*DW-1:0]     win_q, win_d;
  logic                  win_valid_q, win_last_q;
  logic                  accept, complete, frame_end;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

`ifdef CONV_WIN_SOF_EN
  assign col_cur = pix_sof ? '0 : col_q;
  assign row_cur = pix_sof ? '0 : row_q;
`else
  assign col_cur = col_q;
  assign row_cur = row_q;
`endif

  assign frame_end = (row_cur == RW'(IMG_H - 1)) && (col_cur == CW'(IMG_W - 1));
  assign complete  = accept && (row_cur >= RW'(K - 1)) && (col_cur >= CW'(K - 1));

  always_comb begin
    col_d = col_cur + CW'(1);
    row_d = row_cur;
    if (col_cur == CW'(IMG_W - 1)) begin
      col_d = '0;
      row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + RW'(1);
    end
  end

  conv_line_buf #(
    .K          (K),
    .IMG_W      (IMG_W),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (CW)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cur),
    .wdata (pix_data),
    .rdata (lb_rd)
  );

  // Shift every column left; the new right column is the buffered rows
  // at this column with the incoming pixel at the bottom.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K) - 1; c++) begin
        win_d[(r*K+c)*DW +: DW] = win_q[(r*K+c+1)*DW +: DW];
      end
      if (r == int'(K) - 1) begin
        win_d[(r*K+K-1)*DW +: DW] = pix_data;
      end else begin
        win_d[(r*K+K-1)*DW +: DW] = lb_rd[r*DW +: DW];
      end
    end
  end

  // The window register doubles as the output register: it only shifts on
  // an accept, and no accept can happen while a window is stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        col_q <= col_d;
        row_q <= row_d;
        win_q <= win_d;
      end
      if (complete) begin
        win_valid_q <= 1'b1;
        win_last_q  <= frame_end;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_last  = win_last_q;

endmodule
